// File: rtl/hist_lut_remap.sv
// hist_lut_remap
//   Ping-pong LUT remapper for histogram equalisation. Incoming pixels address
//   the active LUT bank while the histogram/CDF stage fills the shadow bank.
//   A committed shadow bank swaps in only after the end-of-frame beat has been
//   accepted, so a frame is never remapped with a mix of two LUTs.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   bypass                          raw pixel passthrough, sampled per beat
//   upd_wr/upd_addr/upd_data        shadow bank write port
//   upd_commit, upd_ready           commit handshake (ready low while pending)
//   sink_valid/ready/data/sop/eop   input pixel stream
//   source_valid/ready/data/sop/eop remapped output stream
//   active_bank, lut_loaded         status
//   swap_pulse                      one-cycle pulse when the banks swap
module hist_lut_remap #(
  parameter int DW = 8,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bypass,
  input  logic          upd_wr,
  input  logic [DW-1:0] upd_addr,
  input  logic [OW-1:0] upd_data,
  input  logic          upd_commit,
  output logic          upd_ready,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic [DW-1:0] sink_data,
  input  logic          sink_sop,
  input  logic          sink_eop,
  output logic          source_valid,
  input  logic          source_ready,
  output logic [OW-1:0] source_data,
  output logic          source_sop,
  output logic          source_eop,
  output logic          active_bank,
  output logic          lut_loaded,
  output logic          swap_pulse
);

  localparam int DEPTH = 1 << DW;

  logic [OW-1:0] r_bank0 [DEPTH];
  logic [OW-1:0] r_bank1 [DEPTH];

  logic          r_active;
  logic          r_loaded;
  logic          r_swap;
  logic          r_pending;
  logic          r_sink_ready;

  // Output skid FIFO. Its entry registers double as the RAM read registers,
  // which gives the one-cycle accept-to-output latency.
  logic [OW-1:0] r_fd [2];
  logic [1:0]    r_fsop;
  logic [1:0]    r_feop;
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_swap;
  logic [OW-1:0] w_raw;
  logic [OW-1:0] w_lut;
  logic [OW-1:0] w_beat;
  logic [1:0]    w_cnt_nxt;

  assign w_push    = sink_valid & r_sink_ready;
  assign w_pop     = (r_cnt != 2'd0) & source_ready;
  assign w_wr_en   = upd_wr & ~r_pending;
  assign w_commit  = upd_commit & ~r_pending;
  // A commit arriving with the eop beat still applies to that frame boundary.
  assign w_swap    = w_push & sink_eop & (r_pending | w_commit);
  assign w_raw     = OW'(sink_data);
  assign w_lut     = r_active ? r_bank1[sink_data] : r_bank0[sink_data];
  assign w_beat    = (r_loaded & ~bypass) ? w_lut : w_raw;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // Shadow bank is the one not being read; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && r_active)
      r_bank0[upd_addr] <= upd_data;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !r_active)
      r_bank1[upd_addr] <= upd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_loaded  <= 1'b0;
      r_swap    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_swap <= w_swap;
      if (w_swap) begin
        r_active  <= ~r_active;
        r_loaded  <= 1'b1;
        r_pending <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_fd[i] <= '0;
      r_fsop       <= '0;
      r_feop       <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_cnt        <= '0;
      r_sink_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_fd[r_wptr]   <= w_beat;
        r_fsop[r_wptr] <= sink_sop;
        r_feop[r_wptr] <= sink_eop;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      r_cnt        <= w_cnt_nxt;
      r_sink_ready <= (w_cnt_nxt < 2'd2);
    end
  end

  assign upd_ready    = ~r_pending;
  assign sink_ready   = r_sink_ready;
  assign source_valid = (r_cnt != 2'd0);
  assign source_data  = r_fd[r_rptr];
  assign source_sop   = r_fsop[r_rptr];
  assign source_eop   = r_feop[r_rptr];
  assign active_bank  = r_active;
  assign lut_loaded   = r_loaded;
  assign swap_pulse   = r_swap;

endmodule
